mem_access_stage: RTL and testbench

- Memory-access pipeline stage, directly upstream of the M->W bus register.
- Accepts one instruction from the execute stage over a valid/ready handshake and performs at most one load or store on an AXI4-Lite style data port.
- Presents load data, a fault flag and the unmodified sideband bundle to the writeback register over a valid/ready handshake.
- One instruction in flight at a time.

---
 rtl/mem_access_stage_if.sv | 51 +++++
 rtl/mem_access_stage.sv | 206 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Handshake and data-bus bundle of the memory-access stage.
// master = the stage itself, slave = execute/writeback/bus side.
interface mem_access_stage_if #(parameter int PT_W = 128);
  // Every channel transfers on a cycle where both valid and ready are high.
  // A valid that is raised stays high, with its payload stable, until that cycle.
  logic            s_valid;
  logic            s_ready;
  logic            ren;
  logic            wen;
  logic [2:0]      funct3;
  logic [31:0]     addr;
  logic [31:0]     wdata_in;
  logic [PT_W-1:0] pt_in;
  logic            m_valid;
  logic            m_ready;
  logic [31:0]     mdata;
  logic            fault;
  logic [PT_W-1:0] pt_out;
  logic [31:0]     araddr;
  logic            arvalid;
  logic            arready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;
  logic [31:0]     awaddr;
  logic            awvalid;
  logic            awready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [2:0]      state_dbg;

  modport master (
    input  s_valid, ren, wen, funct3, addr, wdata_in, pt_in, m_ready,
           arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
    output s_ready, m_valid, mdata, fault, pt_out, araddr, arvalid, rready,
           awaddr, awvalid, wdata, wstrb, wvalid, bready, state_dbg
  );

  modport slave (
    output s_valid, ren, wen, funct3, addr, wdata_in, pt_in, m_ready,
           arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
    input  s_ready, m_valid, mdata, fault, pt_out, araddr, arvalid, rready,
           awaddr, awvalid, wdata, wstrb, wvalid, bready, state_dbg
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: one load/store per instruction over an AXI4-Lite style port.
// Define MEM_TIMEOUT_EN to abandon bus waits after TIMEOUT cycles with fault=1.
module mem_access_stage #(
  parameter int PT_W    = 128,
  parameter int TIMEOUT = 255
) (
  input logic                 clk,
  input logic                 rst,
  mem_access_stage_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    RD_ADDR      = 3'd1,
    RD_DATA      = 3'd2,
    WR_ADDR_DATA = 3'd3,
    WR_RESP      = 3'd4,
    OUT          = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q;
  logic [2:0]      funct3_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;
  logic [PT_W-1:0] pt_q;
  logic [31:0]     mdata_q;
  logic            fault_q;
  logic            aw_done_q, w_done_q;

  logic s_ready, m_valid, arvalid, rready, awvalid, wvalid, bready;
  logic aw_hs, w_hs, wr_both, misalign, waiting, timeout;
  logic [31:0] rshift, load_val, st_data;
  logic [3:0]  st_strb;

  assign waiting = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                   (state_q == WR_ADDR_DATA) || (state_q == WR_RESP);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_q;

  // Counter is zero on entry to either bus wait, since it only runs while waiting.
  always_ff @(posedge clk) begin
    if (rst || !waiting) wait_cnt_q <= '0;
    else                 wait_cnt_q <= wait_cnt_q + 1'b1;
  end

  assign timeout = waiting && (wait_cnt_q >= CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
  assign timeout = 1'b0;
`endif

  assign misalign = (bus.ren || bus.wen) &&
                    (((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                     ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00)));

  assign aw_hs   = awvalid && bus.awready;
  assign w_hs    = wvalid && bus.wready;
  assign wr_both = (aw_done_q || aw_hs) && (w_done_q || w_hs);

  always_comb begin
    rshift   = bus.rdata >> {addr_q[1:0], 3'b000};
    load_val = rshift;
    case (funct3_q)
      3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_val = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_val = {24'h0, rshift[7:0]};
      3'b101:  load_val = {16'h0, rshift[15:0]};
      default: load_val = rshift;
    endcase
  end

  always_comb begin
    st_data = bus.wdata_in << {bus.addr[1:0], 3'b000};
    st_strb = 4'b1111;
    case (bus.funct3[1:0])
      2'b00:   st_strb = 4'b0001 << bus.addr[1:0];
      2'b01:   st_strb = 4'b0011 << bus.addr[1:0];
      default: st_strb = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Handshake completion wins over a timeout landing in the same cycle.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        if (bus.s_valid) begin
          if (misalign)     state_d = OUT;
          else if (bus.ren) state_d = RD_ADDR;
          else if (bus.wen) state_d = WR_ADDR_DATA;
          else              state_d = OUT;
        end
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (bus.arready)  state_d = RD_DATA;
        else if (timeout) state_d = OUT;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (bus.rvalid || timeout) state_d = OUT;
      end
      WR_ADDR_DATA: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        if (wr_both)      state_d = WR_RESP;
        else if (timeout) state_d = OUT;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bus.bvalid || timeout) state_d = OUT;
      end
      OUT: begin
        m_valid = 1'b1;
        if (bus.m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      funct3_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      pt_q      <= '0;
      mdata_q   <= '0;
      fault_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.s_valid) begin
          addr_q    <= bus.addr;
          funct3_q  <= bus.funct3;
          pt_q      <= bus.pt_in;
          mdata_q   <= '0;
          fault_q   <= misalign;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (bus.wen && !bus.ren && !misalign) begin
            wdata_q <= st_data;
            wstrb_q <= st_strb;
          end else begin
            wdata_q <= '0;
            wstrb_q <= '0;
          end
        end
        RD_ADDR: if (!bus.arready && timeout) fault_q <= 1'b1;
        RD_DATA: begin
          if (bus.rvalid) begin
            fault_q <= (bus.rresp != 2'b00);
            mdata_q <= (bus.rresp != 2'b00) ? 32'h0 : load_val;
          end else if (timeout) begin
            fault_q <= 1'b1;
          end
        end
        WR_ADDR_DATA: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
          if (!wr_both && timeout) fault_q <= 1'b1;
        end
        WR_RESP: begin
          if (bus.bvalid)   fault_q <= (bus.bresp != 2'b00);
          else if (timeout) fault_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready   = s_ready;
  assign bus.m_valid   = m_valid;
  assign bus.mdata     = mdata_q;
  assign bus.fault     = fault_q;
  assign bus.pt_out    = pt_q;
  assign bus.araddr    = addr_q;
  assign bus.arvalid   = arvalid;
  assign bus.rready    = rready;
  assign bus.awaddr    = addr_q;
  assign bus.awvalid   = awvalid;
  assign bus.wdata     = wdata_q;
  assign bus.wstrb     = wstrb_q;
  assign bus.wvalid    = wvalid;
  assign bus.bready    = bready;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;
  localparam int PT_W    = 128;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [32:0] exp_q[$];  // {fault, mdata} per instruction, in issue order

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_access_stage_if #(.PT_W(PT_W)) bus();

  mem_access_stage #(.PT_W(PT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [127:0] pt);
    check("s_ready_before_issue", bus.s_ready, 1'b1);
    bus.s_valid  = 1'b1;
    bus.ren      = r;
    bus.wen      = w;
    bus.funct3   = f3;
    bus.addr     = a;
    bus.wdata_in = wd;
    bus.pt_in    = pt;
    tick();
    bus.s_valid = 1'b0;
    bus.ren     = 1'b0;
    bus.wen     = 1'b0;
    bus.pt_in   = '0;
  endtask

  // Waits (bounded) for m_valid, checks against the scoreboard, optional stall, then retires.
  task automatic finish_out(input string tag, input logic [127:0] pt, input int stall);
    int i;
    logic [32:0] e;
    i = 0;
    while (!bus.m_valid && i < 64) begin
      tick();
      i++;
    end
    check({tag, "_m_valid"}, bus.m_valid, 1'b1);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 1'b1, 1'b0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    for (int c = 0; c < stall; c++) begin
      check({tag, "_stall_m_valid"}, bus.m_valid, 1'b1);
      check({tag, "_stall_s_ready"}, bus.s_ready, 1'b0);
      check({tag, "_stall_mdata"}, bus.mdata, e[31:0]);
      check({tag, "_stall_fault"}, bus.fault, e[32]);
      tick();
    end
    check({tag, "_mdata"}, bus.mdata, e[31:0]);
    check({tag, "_fault"}, bus.fault, e[32]);
    check({tag, "_pt_out"}, bus.pt_out, pt);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    check({tag, "_back_to_idle"}, bus.s_ready, 1'b1);
    check({tag, "_m_valid_drop"}, bus.m_valid, 1'b0);
  endtask

  task automatic do_read(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [1:0] resp,
                         input int ar_dly, input int r_dly, input int stall);
    issue(1'b1, 1'b0, f3, a, 32'h0, {4{a}});
    check({tag, "_arvalid"}, bus.arvalid, 1'b1);
    check({tag, "_araddr"}, bus.araddr, a);
    repeat (ar_dly) begin
      tick();
      check({tag, "_arvalid_hold"}, bus.arvalid, 1'b1);
    end
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    check({tag, "_arvalid_drop"}, bus.arvalid, 1'b0);
    check({tag, "_rready"}, bus.rready, 1'b1);
    repeat (r_dly) tick();
    bus.rvalid = 1'b1;
    bus.rdata  = rd;
    bus.rresp  = resp;
    tick();
    bus.rvalid = 1'b0;
    bus.rresp  = 2'b00;
    check({tag, "_rready_drop"}, bus.rready, 1'b0);
    finish_out(tag, {4{a}}, stall);
  endtask

  task automatic do_write(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int aw_dly, input int w_dly,
                          input logic [1:0] resp, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_wstrb);
    logic aw_seen, w_seen;
    int c;
    issue(1'b0, 1'b1, f3, a, wd, {4{wd}});
    check({tag, "_awvalid"}, bus.awvalid, 1'b1);
    check({tag, "_wvalid"}, bus.wvalid, 1'b1);
    check({tag, "_awaddr"}, bus.awaddr, a);
    check({tag, "_wdata"}, bus.wdata, exp_wdata);
    check({tag, "_wstrb"}, bus.wstrb, exp_wstrb);
    aw_seen = 1'b0;
    w_seen  = 1'b0;
    c = 0;
    while (!(aw_seen && w_seen) && c < 20) begin
      bus.awready = (c == aw_dly);
      bus.wready  = (c == w_dly);
      if (bus.awready && bus.awvalid) aw_seen = 1'b1;
      if (bus.wready && bus.wvalid)   w_seen  = 1'b1;
      tick();
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      check({tag, "_awvalid_track"}, bus.awvalid, !aw_seen);
      check({tag, "_wvalid_track"}, bus.wvalid, !w_seen);
      c++;
    end
    check({tag, "_bready"}, bus.bready, 1'b1);
    bus.bvalid = 1'b1;
    bus.bresp  = resp;
    tick();
    bus.bvalid = 1'b0;
    bus.bresp  = 2'b00;
    check({tag, "_bready_drop"}, bus.bready, 1'b0);
    finish_out(tag, {4{wd}}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.s_valid = 0; bus.ren = 0; bus.wen = 0; bus.funct3 = 0; bus.addr = 0;
    bus.wdata_in = 0; bus.pt_in = '0; bus.m_ready = 0;
    bus.arready = 0; bus.rdata = 0; bus.rresp = 0; bus.rvalid = 0;
    bus.awready = 0; bus.wready = 0; bus.bresp = 0; bus.bvalid = 0;

    rst = 1'b1;
    repeat (3) tick();
    check("rst_s_ready", bus.s_ready, 1'b1);
    check("rst_m_valid", bus.m_valid, 1'b0);
    check("rst_bus_ctl", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 5'b0);
    check("rst_mdata", bus.mdata, 32'h0);
    check("rst_fault", bus.fault, 1'b0);
    check("rst_pt_out", bus.pt_out, 128'h0);
    check("rst_addr", {bus.araddr, bus.awaddr}, 64'h0);
    check("rst_wdata_wstrb", {bus.wdata, bus.wstrb}, 36'h0);
    check("rst_state", bus.state_dbg, 3'd0);
    rst = 1'b0;

    // Non-memory instruction: one-cycle latency, sideband passes through.
    exp_q.push_back({1'b0, 32'h0});
    issue(1'b0, 1'b0, 3'b010, 32'h8000_0006, 32'h1111_2222, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    check("nop_m_valid_cycle1", bus.m_valid, 1'b1);
    check("nop_no_bus", {bus.arvalid, bus.awvalid, bus.wvalid}, 3'b0);
    finish_out("nop", 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0);

    // Loads with hand-extracted results.
    exp_q.push_back({1'b0, 32'hFFFF_FF80});
    do_read("lb", 3'b000, 32'h8000_0003, 32'h80FF_1234, 2'b00, 2, 2, 0);
    exp_q.push_back({1'b0, 32'h0000_0080});
    do_read("lbu", 3'b100, 32'h8000_0003, 32'h80FF_1234, 2'b00, 2, 2, 0);
    exp_q.push_back({1'b0, 32'hFFFF_8001});
    do_read("lh", 3'b001, 32'h8000_0002, 32'h8001_0000, 2'b00, 0, 1, 0);
    exp_q.push_back({1'b0, 32'h0000_F00D});
    do_read("lhu", 3'b101, 32'h8000_0000, 32'h1234_F00D, 2'b00, 1, 0, 0);
    exp_q.push_back({1'b0, 32'hCAFE_BABE});
    do_read("lw", 3'b010, 32'h8000_0008, 32'hCAFE_BABE, 2'b00, 0, 0, 0);
    exp_q.push_back({1'b0, 32'h0000_0012});
    do_read("lbu_b1", 3'b100, 32'h8000_0001, 32'hAB00_1200, 2'b00, 0, 0, 0);

    // Stores: strobes/lane shifting and independent AW/W handshakes.
    exp_q.push_back({1'b0, 32'h0});
    do_write("sh", 3'b001, 32'h8000_0002, 32'h0000_ABCD, 0, 1, 2'b00, 32'hABCD_0000, 4'b1100);
    exp_q.push_back({1'b0, 32'h0});
    do_write("sb", 3'b000, 32'h8000_0001, 32'h1234_5655, 2, 0, 2'b00, 32'h3456_5500, 4'b0010);
    exp_q.push_back({1'b1, 32'h0});
    do_write("sw_err", 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 1, 1, 2'b10, 32'hDEAD_BEEF, 4'b1111);

    // Misaligned accesses fault without bus traffic.
    exp_q.push_back({1'b1, 32'h0});
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0006, 32'h0, 128'h6);
    check("mis_lw_m_valid", bus.m_valid, 1'b1);
    check("mis_lw_no_ar", bus.arvalid, 1'b0);
    finish_out("mis_lw", 128'h6, 0);
    exp_q.push_back({1'b1, 32'h0});
    issue(1'b0, 1'b1, 3'b001, 32'h8000_0003, 32'h55, 128'h7);
    check("mis_sh_no_aw_w", {bus.awvalid, bus.wvalid}, 2'b0);
    finish_out("mis_sh", 128'h7, 0);

    // Load bus error, then writeback stalls for 5 cycles.
    exp_q.push_back({1'b1, 32'h0});
    do_read("lw_err", 3'b010, 32'h8000_0010, 32'h1234_5678, 2'b10, 0, 0, 5);

    // Synchronous reset while in RD_DATA abandons the access.
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0014, 32'h0, 128'h9);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    check("rst_mid_rready", bus.rready, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_state", bus.state_dbg, 3'd0);
    check("rst_mid_s_ready", bus.s_ready, 1'b1);
    check("rst_mid_ctl", {bus.m_valid, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 6'b0);
    exp_q.push_back({1'b0, 32'hFFFF_FFA5});
    do_read("lb_after_rst", 3'b000, 32'h8000_0000, 32'h0000_00A5, 2'b00, 0, 0, 0);

`ifdef MEM_TIMEOUT_EN
    begin
      int cyc;
      exp_q.push_back({1'b1, 32'h0});
      issue(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0, 128'hA);
      cyc = 0;
      while (!bus.m_valid && cyc < 40) begin
        tick();
        cyc++;
      end
      check("to_cycles", cyc, 16);
      check("to_arvalid_drop", bus.arvalid, 1'b0);
      finish_out("to", 128'hA, 0);
    end
`else
    // Without the timeout the stage keeps waiting for arready.
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0, 128'hA);
    repeat (40) tick();
    check("nto_arvalid_hold", bus.arvalid, 1'b1);
    check("nto_no_m_valid", bus.m_valid, 1'b0);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h0BAD_F00D;
    tick();
    bus.rvalid = 1'b0;
    exp_q.push_back({1'b0, 32'h0BAD_F00D});
    finish_out("nto", 128'hA, 0);
`endif

    check("scoreboard_drained", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
